// File: rtl/pem_pkg.sv
// Shared state encoding and default sizing for the pulse event monitor.
package pem_pkg;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_WIN_W      = 32;
  localparam int DEF_CLR_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_WAIT  = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } pem_state_t;

endpackage

// File: rtl/pem_window_timer.sv
// Test-window down-counter: load has priority, counts down to zero and holds there.
module pem_window_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/pulse_event_monitor.sv
// Counts flag events inside a timed window, clearing the upstream edge latch after
// each event; reports count, pass/fail against an expected count, and overflow.
module pulse_event_monitor
  import pem_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flag_i,
  output logic             clr_o,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIN_W-1:0] window_i,
  input  logic [CNT_W-1:0] expected_i,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             overflow_o
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES - 1);

  pem_state_t       state, nxt;
  logic [CNT_W-1:0] exp_q, exp_nxt, cnt_nxt;
  logic             ovf_nxt;
  logic [CLR_W-1:0] clr_cnt, clr_nxt;
  logic             t_load, t_en, t_zero, t_last;
  logic [WIN_W-1:0] t_value;

  pem_window_timer #(.W(WIN_W)) u_timer (
    .clk      (clk),
    .clrn     (clrn),
    .load     (t_load),
    .en       (t_en),
    .load_val (window_i),
    .value    (t_value),
    .zero     (t_zero)
  );

  assign t_en   = (state == S_WAIT) || (state == S_CLEAR);
  // Timer value 1 means this is the final window cycle.
  assign t_last = t_zero || (t_value == WIN_W'(1));

  always_comb begin
    nxt     = state;
    cnt_nxt = count_o;
    ovf_nxt = overflow_o;
    exp_nxt = exp_q;
    clr_nxt = clr_cnt;
    t_load  = 1'b0;
    if (abort_i) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            nxt     = S_ARM;
            cnt_nxt = '0;
            ovf_nxt = 1'b0;
            exp_nxt = expected_i;
            t_load  = 1'b1;
          end
        end
        S_ARM: begin
          if (!flag_i) nxt = S_WAIT;
        end
        S_WAIT: begin
          if (t_zero) begin
            nxt = S_DONE;
          end else begin
            if (flag_i) begin
              if (count_o == '1) ovf_nxt = 1'b1;
              else               cnt_nxt = count_o + CNT_W'(1);
            end
            if (t_last) begin
              nxt = S_DONE;
            end else if (flag_i) begin
              nxt     = S_CLEAR;
              clr_nxt = CLR_LOAD;
            end
          end
        end
        S_CLEAR: begin
          if (t_last) begin
            nxt = S_DONE;
          end else if (clr_cnt == '0) begin
            if (!flag_i) nxt = S_WAIT;
          end else begin
            clr_nxt = clr_cnt - CLR_W'(1);
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= S_IDLE;
      count_o    <= '0;
      overflow_o <= 1'b0;
      exp_q      <= '0;
      clr_cnt    <= '0;
      clr_o      <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
    end else begin
      state      <= nxt;
      count_o    <= cnt_nxt;
      overflow_o <= ovf_nxt;
      exp_q      <= exp_nxt;
      clr_cnt    <= clr_nxt;
      clr_o      <= (nxt != S_WAIT);
      busy_o     <= (nxt == S_ARM) || (nxt == S_WAIT) || (nxt == S_CLEAR);
      done_o     <= (nxt == S_DONE);
      pass_o     <= (nxt == S_DONE) && (cnt_nxt == exp_nxt) && !ovf_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_event_monitor.sv
// Bench for pulse_event_monitor: directed scenarios plus randomized windows checked
// against an event-list reference model with a post-event dead time.
module tb_pulse_event_monitor;

  localparam int CNT_W = 4;
  localparam int WIN_W = 16;
  localparam int CLR   = 2;
  localparam int MAXK  = 256;

  logic             clk = 1'b0;
  logic             clrn;
  logic             flag;
  logic             clr_o;
  logic             start;
  logic             abort;
  logic [WIN_W-1:0] window;
  logic [CNT_W-1:0] expected;
  logic [CNT_W-1:0] count_o;
  logic             busy_o, done_o, pass_o, overflow_o;

  int checks   = 0;
  int failures = 0;

  bit flags   [0:MAXK-1];
  bit exp_clr [0:MAXK-1];
  int events;

  pulse_event_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W), .CLR_CYCLES(CLR)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .flag_i     (flag),
    .clr_o      (clr_o),
    .start_i    (start),
    .abort_i    (abort),
    .window_i   (window),
    .expected_i (expected),
    .count_o    (count_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic clear_flags();
    for (int k = 0; k < MAXK; k++) flags[k] = 1'b0;
  endtask

  // An event is any flag seen while not clearing; after it the monitor is blind for
  // at least CLR window cycles and until the flag drops. Window is n cycles long.
  task automatic compute_model(input int n);
    bit blocked;
    int hold;
    blocked = 1'b0;
    hold    = 0;
    events  = 0;
    for (int k = 0; k < MAXK; k++) begin
      exp_clr[k] = blocked;
      if (k < n) begin
        if (!blocked) begin
          if (flags[k]) begin
            events++;
            blocked = 1'b1;
            hold    = 0;
          end
        end else begin
          hold++;
          if (hold >= CLR && !flags[k]) blocked = 1'b0;
        end
      end
    end
  endtask

  // Drives one test window. stop_at >= 0 cuts the run at that window cycle with an
  // abort (stop_rst=0) or an asynchronous reset (stop_rst=1).
  task automatic run_window(input int n, input int exp, input int arm_hold,
                            input int stop_at, input bit stop_rst, input bit noise);
    int cyc;
    @(negedge clk);
    start    = 1'b1;
    window   = WIN_W'(n);
    expected = CNT_W'(exp);
    flag     = 1'($urandom_range(0, 1));
    abort    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < arm_hold; j++) begin
      checks++;
      if (busy_o !== 1'b1 || clr_o !== 1'b1 || done_o !== 1'b0)
        $display("FAIL arm_hold busy=%0b clr=%0b done=%0b required 1 1 0", busy_o, clr_o, done_o);
      flag = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (busy_o !== 1'b1 || clr_o !== 1'b1 || count_o !== '0 || overflow_o !== 1'b0 || pass_o !== 1'b0)
      $display("FAIL arm_entry busy=%0b clr=%0b count=%0d ovf=%0b pass=%0b required 1 1 0 0 0",
               busy_o, clr_o, count_o, overflow_o, pass_o);
    flag = 1'b0;
    @(posedge clk);
    cyc = (n == 0) ? 1 : n;
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk);
      checks++;
      if (clr_o !== exp_clr[k] || busy_o !== 1'b1 || done_o !== 1'b0) begin
        failures++;
        $display("FAIL window_cycle k=%0d clr=%0b busy=%0b done=%0b required clr=%0b busy=1 done=0",
                 k, clr_o, busy_o, done_o, exp_clr[k]);
      end
      if (k == stop_at) begin
        if (stop_rst) begin
          #1 clrn = 1'b0;
          #1;
        end else begin
          abort = 1'b1;
          @(posedge clk);
          #1 abort = 1'b0;
        end
        return;
      end
      flag  = flags[k];
      start = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    flag  = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0; flag = 1'b0; start = 1'b0; abort = 1'b0; window = '0; expected = '0;
    #12;
    checks++;
    if (clr_o !== 1'b1 || count_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
        pass_o !== 1'b0 || overflow_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_values clr=%0b count=%0d busy=%0b done=%0b pass=%0b ovf=%0b required 1 0 0 0 0 0",
               clr_o, count_o, busy_o, done_o, pass_o, overflow_o);
    end
    @(negedge clk);
    clrn = 1'b1;
    flag = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (clr_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || count_o !== '0) begin
      failures++;
      $display("FAIL idle_after_reset clr=%0b busy=%0b done=%0b count=%0d required 1 0 0 0",
               clr_o, busy_o, done_o, count_o);
    end
    flag = 1'b0;
  endtask

  task automatic test_basic();
    clear_flags();
    flags[10] = 1'b1; flags[20] = 1'b1; flags[30] = 1'b1;
    compute_model(100);
    run_window(100, 3, 0, -1, 1'b0, 1'b0);
    checks++;
    if (done_o !== 1'b1 || count_o !== 4'd3 || pass_o !== 1'b1 || overflow_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL basic done=%0b count=%0d pass=%0b ovf=%0b busy=%0b required 1 3 1 0 0",
               done_o, count_o, pass_o, overflow_o, busy_o);
    end
  endtask

  task automatic test_held_flag();
    clear_flags();
    for (int k = 5; k < 10; k++) flags[k] = 1'b1;
    compute_model(40);
    run_window(40, 1, 2, -1, 1'b0, 1'b0);
    checks++;
    if (done_o !== 1'b1 || count_o !== 4'd1 || pass_o !== 1'b1) begin
      failures++;
      $display("FAIL held_flag done=%0b count=%0d pass=%0b required 1 1 1", done_o, count_o, pass_o);
    end
  endtask

  task automatic test_last_cycle();
    clear_flags();
    flags[5] = 1'b1; flags[19] = 1'b1;
    compute_model(20);
    run_window(20, 2, 0, -1, 1'b0, 1'b0);
    checks++;
    if (done_o !== 1'b1 || count_o !== 4'd2 || pass_o !== 1'b1) begin
      failures++;
      $display("FAIL last_cycle done=%0b count=%0d pass=%0b required 1 2 1", done_o, count_o, pass_o);
    end
  endtask

  task automatic test_overflow();
    clear_flags();
    for (int e = 0; e < 17; e++) flags[e * 4] = 1'b1;
    compute_model(70);
    run_window(70, 15, 0, -1, 1'b0, 1'b0);
    checks++;
    if (done_o !== 1'b1 || count_o !== 4'd15 || overflow_o !== 1'b1 || pass_o !== 1'b0) begin
      failures++;
      $display("FAIL overflow done=%0b count=%0d ovf=%0b pass=%0b required 1 15 1 0",
               done_o, count_o, overflow_o, pass_o);
    end
  endtask

  task automatic test_abort();
    clear_flags();
    flags[2] = 1'b1; flags[6] = 1'b1;
    compute_model(100);
    run_window(100, 2, 0, 12, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || clr_o !== 1'b1 || count_o !== 4'd2 || done_o !== 1'b0 || pass_o !== 1'b0) begin
      failures++;
      $display("FAIL abort busy=%0b clr=%0b count=%0d done=%0b pass=%0b required 0 1 2 0 0",
               busy_o, clr_o, count_o, done_o, pass_o);
    end
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || count_o !== 4'd2) begin
      failures++;
      $display("FAIL abort_priority busy=%0b count=%0d required 0 2", busy_o, count_o);
    end
  endtask

  task automatic test_reset_in_clear();
    clear_flags();
    flags[3] = 1'b1;
    compute_model(50);
    run_window(50, 1, 0, 4, 1'b1, 1'b0);
    checks++;
    if (clr_o !== 1'b1 || count_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
        pass_o !== 1'b0 || overflow_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_clear clr=%0b count=%0d busy=%0b done=%0b pass=%0b ovf=%0b required 1 0 0 0 0 0",
               clr_o, count_o, busy_o, done_o, pass_o, overflow_o);
    end
    @(negedge clk);
    clrn = 1'b1;
    clear_flags();
    flags[0] = 1'b1;
    compute_model(0);
    run_window(0, 0, 0, -1, 1'b0, 1'b0);
    checks++;
    if (done_o !== 1'b1 || count_o !== 4'd0 || pass_o !== 1'b1) begin
      failures++;
      $display("FAIL zero_window done=%0b count=%0d pass=%0b required 1 0 1", done_o, count_o, pass_o);
    end
  endtask

  task automatic test_random();
    int n, exp, exp_cnt;
    bit exp_ovf, exp_pass;
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 60);
      clear_flags();
      for (int k = 0; k < MAXK; k++) flags[k] = ($urandom_range(0, 2) == 0);
      compute_model(n);
      exp_cnt = (events > 15) ? 15 : events;
      exp_ovf = (events > 15);
      exp = ($urandom_range(0, 1) == 1) ? exp_cnt : int'($urandom_range(0, 15));
      exp_pass = (exp == exp_cnt) && !exp_ovf;
      run_window(n, exp, $urandom_range(0, 3), -1, 1'b0, 1'b1);
      checks++;
      if (done_o !== 1'b1 || count_o !== CNT_W'(exp_cnt) || overflow_o !== exp_ovf || pass_o !== exp_pass) begin
        failures++;
        $display("FAIL random r=%0d n=%0d done=%0b count=%0d ovf=%0b pass=%0b required 1 %0d %0b %0b",
                 r, n, done_o, count_o, overflow_o, pass_o, exp_cnt, exp_ovf, exp_pass);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_flag();
    test_last_cycle();
    test_overflow();
    test_abort();
    test_reset_in_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_event_monitor.md
PULSE_EVENT_MONITOR -- requirements
Module: pulse_event_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, event counter width.
REQ-002 SHALL have parameter WIN_W, default 32, test-window timer width in clk cycles.
REQ-003 SHALL have parameter CLR_CYCLES, default 2, minimum clr_o assertion length per event.
REQ-004 SHALL have ports: clk  in  1  system clock; clrn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: flag_i  in  1  clk-synchronous event flag from the edge-latch/synchroniser stage.
REQ-006 SHALL have port: clr_o  out  1  active-high clear to the edge-latch stage.
REQ-007 SHALL have ports: start_i  in  1  begin test; abort_i  in  1  cancel test.
REQ-008 SHALL have ports: window_i  in  WIN_W  window length; expected_i  in  CNT_W  expected event count.
REQ-009 SHALL have ports: count_o  out  CNT_W  events counted; busy_o, done_o, pass_o, overflow_o  out  1 each.

Function
REQ-010 SHALL implement FSM states IDLE, ARM, WAIT, CLEAR, DONE.
REQ-011 SHALL drive clr_o=1 in IDLE, ARM, CLEAR, DONE and clr_o=0 only in WAIT (registered output).
REQ-012 SHALL, on start_i in IDLE or DONE: zero count_o, clear overflow_o, load timer with window_i, capture expected_i, enter ARM.
REQ-013 SHALL ignore start_i in ARM, WAIT, CLEAR.
REQ-014 SHALL remain in ARM at least one cycle and exit to WAIT on the first cycle flag_i==0; timer does not run in ARM.
REQ-015 SHALL, in WAIT, decrement timer every cycle; timer==0 on entry or during WAIT -> DONE.
REQ-016 SHALL, in WAIT with flag_i==1, increment count_o by 1 (saturating) and enter CLEAR the next cycle.
REQ-017 SHALL, when flag_i==1 and timer reaches 0 in the same WAIT cycle, count the event and enter DONE.
REQ-018 SHALL keep the timer running in CLEAR; exit to WAIT once CLR_CYCLES cycles have elapsed and flag_i==0; timer expiry in CLEAR -> DONE.
REQ-019 SHALL not count flag_i while in CLEAR (events during clearing are lost by design).
REQ-020 SHALL saturate count_o at 2^CNT_W-1 and set overflow_o sticky until next start.
REQ-021 SHALL, in DONE, hold done_o=1 and pass_o=(count_o==captured expected) AND NOT overflow_o; both 0 in all other states.
REQ-022 SHALL drive busy_o=1 in ARM, WAIT, CLEAR.
REQ-023 SHALL, on abort_i in any state, go to IDLE next cycle, holding count_o; abort_i has priority over start_i.
REQ-024 SHALL treat window_i==0 as a zero-length window: ARM -> WAIT -> DONE with count 0.

Reset
REQ-025 SHALL, while clrn==0, force state IDLE, clr_o=1, count_o=0, timer=0, busy_o=done_o=pass_o=overflow_o=0.
REQ-026 SHALL release from reset synchronously to clk on the first edge after clrn rises; no action before start_i.

Structure
REQ-027 SHALL place the state enum and default parameter constants in shared package pem_pkg.
REQ-028 SHALL implement the window down-counter as sub-module pem_window_timer (load, enable, zero flag).
REQ-029 SHALL register all outputs; no combinational path from inputs to outputs.

Verification
REQ-030 SHALL cover: window_i=100, 3 flag pulses spaced 10 cycles, expected_i=3 -> done_o=1, count_o=3, pass_o=1.
REQ-031 SHALL cover: flag_i held high 5 cycles in WAIT -> count_o increments once, clr_o high until flag_i low.
REQ-032 SHALL cover: flag_i=1 on final window cycle -> counted, DONE next cycle, count_o includes it.
REQ-033 SHALL cover: CNT_W=4, 17 events -> count_o=15, overflow_o=1, pass_o=0.
REQ-034 SHALL cover: abort_i mid-WAIT with count_o=2 -> IDLE next cycle, clr_o=1, count_o=2, done_o=0.
REQ-035 SHALL cover: clrn asserted during CLEAR -> all outputs at reset values immediately; window_i=0 run -> DONE, count_o=0.
